// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_t : sequencing FSM states (IDLE / REQ / RESP)
//   arb_owner_t : which requester owns the in-flight transaction
//   ARB_ADDR_W, ARB_DATA_W, ARB_BE_W : default widths of the memory port
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three handshakes around the arbiter:
//   if_*  : instruction-fetch requester (req/addr in, gnt/rvalid/rdata out)
//   ma_*  : data requester (req/we/addr/wdata/be in, gnt/rvalid/rdata out)
//   mem_* : single-ported memory (req/we/addr/wdata/be out, gnt/rvalid/rdata in)
// Modports:
//   master : the arbiter's view
//   slave  : the view of the requesters and the memory around it
// ---------------------------------------------------------------------------
interface mem_arbiter_if
  import core_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic [BE_W-1:0]   ma_be;
  logic              ma_gnt;
  logic              ma_rvalid;
  logic [DATA_W-1:0] ma_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ma_req, ma_we, ma_addr, ma_wdata, ma_be,
    output ma_gnt, ma_rvalid, ma_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ma_req, ma_we, ma_addr, ma_wdata, ma_be,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   if_req, ma_req : pending requests
//   last_gnt       : owner of the most recent capture
//   winner         : requester to grant (meaningful only when a request is up)
// Build option ARB_RR_EN:
//   undefined -> fixed priority, MA always beats IF
//   defined   -> round-robin on a tie, based on last_gnt
// ---------------------------------------------------------------------------
module mem_arb_pick
  import core_pkg::*;
(
  input  logic       if_req,
  input  logic       ma_req,
  input  arb_owner_t last_gnt,
  output arb_owner_t winner
);

`ifdef ARB_RR_EN
  // On a tie the requester that did not win last time goes next; a lone
  // requester always wins regardless of history.
  always_comb begin
    winner = OWN_IF;
    if (if_req && ma_req) begin
      winner = (last_gnt == OWN_MA) ? OWN_IF : OWN_MA;
    end else if (ma_req) begin
      winner = OWN_MA;
    end
  end
`else
  // History is not consulted in the fixed-priority build.
  logic unused_last_gnt;
  assign unused_last_gnt = (last_gnt == OWN_MA) ^ if_req;

  // Data accesses stall the pipeline harder than fetches, so MA always wins.
  always_comb begin
    winner = OWN_IF;
    if (ma_req) begin
      winner = OWN_MA;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the IF (fetch) and MA (load/store)
// requesters. One transaction is outstanding at a time:
//   IDLE --req--> REQ --mem_gnt--> RESP --mem_rvalid--> IDLE
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : mem_arbiter_if.master (requester and memory handshakes)
//   busy : FSM is not in IDLE
// All outputs are registered. Arbitration policy is selected by ARB_RR_EN
// inside mem_arb_pick; this FSM is the same in both builds.
// ---------------------------------------------------------------------------
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.master bus,
  output logic busy
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  arb_owner_t        winner;

  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              ma_gnt_q, ma_gnt_d;
  logic              ma_rvalid_q, ma_rvalid_d;
  logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;

  mem_arb_pick u_pick (
    .if_req   (bus.if_req),
    .ma_req   (bus.ma_req),
    .last_gnt (last_q),
    .winner   (winner)
  );

  // Next-state and output logic. Every register holds by default and the
  // grant/rvalid pulses default low, so each state only states its changes.
  // In IDLE the winner's payload is latched straight into the mem_* command
  // registers; a fetch always reads a full word. In RESP a store completion
  // returns zero data, and only the owner's rdata register is touched.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_gnt_d    = 1'b0;
    ma_rvalid_d = 1'b0;
    ma_rdata_d  = ma_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      ARB_IDLE: begin
        if (bus.if_req || bus.ma_req) begin
          owner_d   = winner;
          last_d    = winner;
          mem_req_d = 1'b1;
          state_d   = ARB_REQ;
          if (winner == OWN_MA) begin
            ma_gnt_d    = 1'b1;
            mem_we_d    = bus.ma_we;
            mem_addr_d  = bus.ma_addr;
            mem_wdata_d = bus.ma_wdata;
            mem_be_d    = bus.ma_be;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end

      ARB_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
        end
      end

      ARB_RESP: begin
        if (bus.mem_rvalid) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_MA) begin
            ma_rvalid_d = 1'b1;
            ma_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any in-flight transaction:
  // everything clears immediately and no rvalid is ever produced for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ma_gnt_q    <= 1'b0;
      ma_rvalid_q <= 1'b0;
      ma_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ma_gnt_q    <= ma_gnt_d;
      ma_rvalid_q <= ma_rvalid_d;
      ma_rdata_q  <= ma_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ma_gnt    = ma_gnt_q;
  assign bus.ma_rvalid = ma_rvalid_q;
  assign bus.ma_rdata  = ma_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives the arbiter from table vectors plus hand-written corner sequences.
// Expected responses are pushed to a scoreboard queue when a request is
// driven and popped by a monitor whenever an rvalid pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import core_pkg::*;

  logic clk;
  logic rst;
  logic busy;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                  is_ma;
    bit                  we;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [ARB_BE_W-1:0] be;
    int                  gnt_wait;
    int                  rv_wait;
    logic [31:0]         mem_rdata;
    logic [31:0]         exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_ma;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[6];
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_if_data = '0;
  logic [31:0] last_ma_data = '0;

  // Single comparison point: every check steps the counters used in the summary.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every output of the arbiter must read zero (reset state).
  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {bus.if_gnt, bus.if_rvalid, bus.ma_gnt, bus.ma_rvalid,
                                 bus.mem_req, bus.mem_we, busy}, 0);
    checkOutput({tag, "_if_rdata"}, bus.if_rdata, 0);
    checkOutput({tag, "_ma_rdata"}, bus.ma_rdata, 0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    checkOutput({tag, "_mem_be"}, bus.mem_be, 0);
  endtask

  // Wait (bounded) for a grant pulse; reports which requester got it and
  // how many cycles after the request was driven.
  task automatic waitGnt(output bit got_ma, output int cycles, output bit ok);
    got_ma = 1'b0;
    ok     = 1'b0;
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.ma_gnt) begin
        got_ma = bus.ma_gnt;
        cycles = c;
        ok     = 1'b1;
        checkOutput("gnt_onehot", {bus.if_gnt, bus.ma_gnt}, got_ma ? 2'b01 : 2'b10);
        return;
      end
    end
    checkOutput("gnt_timeout", 0, 1);
  endtask

  // Memory model: called in the cycle the grant is seen. Stalls mem_gnt,
  // then stalls mem_rvalid, then returns rd; checks stability and the
  // exact cycle of the owner's rvalid pulse.
  task automatic serveMem(input int gw, input int rw, input logic [31:0] rd,
                          input bit is_ma);
    logic [31:0]         a0;
    logic [31:0]         w0;
    logic [ARB_BE_W-1:0] b0;
    logic                we0;
    a0  = bus.mem_addr;
    w0  = bus.mem_wdata;
    b0  = bus.mem_be;
    we0 = bus.mem_we;
    for (int i = 0; i < gw; i++) begin
      bus.mem_gnt = 1'b0;
      @(negedge clk);
      checkOutput("stall_mem_req", bus.mem_req, 1);
      checkOutput("stall_payload", (bus.mem_addr == a0) && (bus.mem_wdata == w0) &&
                                   (bus.mem_be == b0) && (bus.mem_we == we0), 1);
      checkOutput("stall_gnt_low", {bus.if_gnt, bus.ma_gnt}, 0);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    checkOutput("resp_mem_req", bus.mem_req, 0);
    checkOutput("resp_busy", busy, 1);
    checkOutput("resp_gnt_low", {bus.if_gnt, bus.ma_gnt}, 0);
    repeat (rw) @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    checkOutput("rvalid_on_time", is_ma ? bus.ma_rvalid : bus.if_rvalid, 1);
    checkOutput("idle_after", busy, 0);
  endtask

  // Apply one table record: raise the request, check the captured command,
  // drop the request, then let the memory model finish it.
  task automatic applyStimulus(input vec_t v);
    bit got_ma;
    int cycles;
    bit ok;
    if (v.is_ma) begin
      bus.ma_req   = 1'b1;
      bus.ma_we    = v.we;
      bus.ma_addr  = v.addr;
      bus.ma_wdata = v.wdata;
      bus.ma_be    = v.be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    sb_q.push_back('{is_ma: v.is_ma, data: v.exp_rdata});
    waitGnt(got_ma, cycles, ok);
    bus.if_req = 1'b0;
    bus.ma_req = 1'b0;
    if (!ok) return;
    checkOutput("gnt_latency", cycles, 1);
    checkOutput("gnt_owner", got_ma, v.is_ma);
    checkOutput("cmd_req", {bus.mem_req, busy}, 2'b11);
    checkOutput("cmd_addr", bus.mem_addr, v.addr);
    checkOutput("cmd_we", bus.mem_we, v.is_ma ? v.we : 1'b0);
    checkOutput("cmd_wdata", bus.mem_wdata, v.is_ma ? v.wdata : 32'h0);
    checkOutput("cmd_be", bus.mem_be, v.is_ma ? v.be : 4'hF);
    serveMem(v.gnt_wait, v.rv_wait, v.mem_rdata, v.is_ma);
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expected
  // response, and the other requester's rdata must not move.
  always @(negedge clk) begin
    if (rst && (bus.if_rvalid || bus.ma_rvalid)) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rvalid", {bus.if_rvalid, bus.ma_rvalid}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("rvalid_ma", bus.ma_rvalid, mon_e.is_ma);
        checkOutput("rvalid_if", bus.if_rvalid, !mon_e.is_ma);
        if (mon_e.is_ma) begin
          checkOutput("ma_rdata", bus.ma_rdata, mon_e.data);
          checkOutput("if_rdata_hold", bus.if_rdata, last_if_data);
          last_ma_data = mon_e.data;
        end else begin
          checkOutput("if_rdata", bus.if_rdata, mon_e.data);
          checkOutput("ma_rdata_hold", bus.ma_rdata, last_ma_data);
          last_if_data = mon_e.data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          got_ma;
    int          cycles;
    bit          ok;
    bit          order[4];
    logic [31:0] d;

    // is_ma, we, addr, wdata, be, gnt_wait, rv_wait, mem_rdata, exp_rdata
    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 0, 32'h00A0_0513, 32'h00A0_0513};
    vecs[1] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 0, 32'h5555_5555, 32'h0};
    vecs[2] = '{1, 0, 32'h0000_0200, 32'h1111_2222, 4'hC, 1, 2, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3] = '{0, 0, 32'h0000_0014, 32'h0,         4'hF, 0, 1, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{1, 1, 32'h0000_0300, 32'h0BAD_F00D, 4'hF, 0, 0, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{0, 0, 32'hFFFF_FFFC, 32'h0,         4'hF, 2, 0, 32'h8000_0001, 32'h8000_0001};

`ifdef ARB_RR_EN
    order = '{1, 0, 1, 0};
`else
    order = '{1, 1, 1, 1};
`endif

    rst = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.ma_req = 1'b0;  bus.ma_we = 1'b0;  bus.ma_addr = '0;
    bus.ma_wdata = '0;  bus.ma_be = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Both requesters held for four transactions; the last capture was a
    // fetch, so a round-robin build starts with MA as well.
    $display("[TB] contention");
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0400;
    bus.ma_req = 1'b1;  bus.ma_we = 1'b0;  bus.ma_addr = 32'h0000_0800;
    bus.ma_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      d = 32'hA000_0000 + 32'(k);
      sb_q.push_back('{is_ma: order[k], data: d});
      waitGnt(got_ma, cycles, ok);
      checkOutput("tie_owner", got_ma, order[k]);
      checkOutput("tie_latency", cycles, 1);
      checkOutput("tie_addr", bus.mem_addr, order[k] ? 32'h800 : 32'h400);
      if (k == 3) begin
        bus.if_req = 1'b0;
        bus.ma_req = 1'b0;
      end
      serveMem(0, 0, d, order[k]);
    end
    @(negedge clk);
    checkOutput("tie_done", {busy, bus.if_gnt, bus.ma_gnt}, 0);

    // Stray memory handshakes while IDLE, then mem_rvalid while in REQ.
    $display("[TB] stray handshakes");
    bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    checkOutput("idle_stray", {busy, bus.mem_req, bus.if_rvalid, bus.ma_rvalid}, 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0020;
    sb_q.push_back('{is_ma: 1'b0, data: 32'h1357_9BDF});
    waitGnt(got_ma, cycles, ok);
    bus.if_req = 1'b0;
    checkOutput("stray_owner", got_ma, 0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    checkOutput("req_stray", {busy, bus.mem_req, bus.if_rvalid, bus.ma_rvalid}, 4'b1100);
    serveMem(0, 0, 32'h1357_9BDF, 1'b0);

    // Reset asserted in RESP while the memory answers: abandoned, no rvalid.
    $display("[TB] reset mid-transaction");
    bus.ma_req = 1'b1; bus.ma_we = 1'b0; bus.ma_addr = 32'h0000_0500;
    waitGnt(got_ma, cycles, ok);
    bus.ma_req = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    checkOutput("pre_rst_busy", busy, 1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077;
    #2 rst = 1'b0;
    #1 checkAllZero("rst_async");
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    checkAllZero("rst_held");
    last_if_data = '0;
    last_ma_data = '0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
    rst = 1'b1;
    sb_q.push_back('{is_ma: 1'b0, data: 32'h2468_ACE0});
    waitGnt(got_ma, cycles, ok);
    bus.if_req = 1'b0;
    checkOutput("post_rst_owner", got_ma, 0);
    checkOutput("post_rst_latency", cycles, 1);
    checkOutput("post_rst_addr", bus.mem_addr, 32'h44);
    serveMem(0, 0, 32'h2468_ACE0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
